// File: rtl/reg_pipe_hs.sv
// reg_pipe_hs: STAGES-deep valid/ready register chain with bubble collapse and occupancy count.
// Define REG_PIPE_HS_FLUSH_EN to add the synchronous i_flush port.
module reg_pipe_hs #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    STAGES     = 2,
   parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [DATA_WIDTH-1:0]         i_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [DATA_WIDTH-1:0]         o_data,
   output logic [$clog2(STAGES+1)-1:0]   o_count
`ifdef REG_PIPE_HS_FLUSH_EN
   ,input  logic                         i_flush
`endif
);
   localparam int CW = $clog2(STAGES+1);
   logic [STAGES-1:0]     vld, up_vld;
   logic [STAGES:0]       rdy;
   logic [DATA_WIDTH-1:0] data    [STAGES];
   logic [DATA_WIDTH-1:0] up_data [STAGES];
   logic                  flush;
`ifdef REG_PIPE_HS_FLUSH_EN
   assign flush = i_flush;
`else
   assign flush = 1'b0;
`endif
   // An empty stage is always ready, so ready ripples from i_ready back to o_ready.
   always_comb begin
      rdy[STAGES] = i_ready;
      for (int k = STAGES-1; k >= 0; k--) rdy[k] = !vld[k] || rdy[k+1];
   end
   always_comb begin
      up_vld[0]  = i_valid;
      up_data[0] = i_data;
      for (int k = 1; k < STAGES; k++) begin
         up_vld[k]  = vld[k-1];
         up_data[k] = data[k-1];
      end
   end
   always_comb begin
      o_count = '0;
      for (int k = 0; k < STAGES; k++) o_count = o_count + CW'(vld[k]);
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld <= '0;
         for (int k = 0; k < STAGES; k++) data[k] <= RST_VALUE;
      end else begin
         vld <= flush ? '0 : (rdy[STAGES-1:0] & up_vld) | (~rdy[STAGES-1:0] & vld);
         for (int k = 0; k < STAGES; k++)
            if (!flush && rdy[k] && up_vld[k]) data[k] <= up_data[k];
      end
   end
   assign o_valid = vld[STAGES-1];
   assign o_data  = data[STAGES-1];
   assign o_ready = rdy[0];
endmodule

// File: tb/tb_reg_pipe_hs.sv
// tb_reg_pipe_hs: randomized bench for reg_pipe_hs against a queue-of-entries reference model.
module tb_reg_pipe_hs;
   localparam int S = 3;
   localparam logic [31:0] RV = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        i_rst = 1'b0, i_valid = 1'b0, i_ready = 1'b0, flush = 1'b0;
   logic [31:0] i_data = '0;
   logic        o_ready, o_valid;
   logic [31:0] o_data;
   logic [1:0]  o_count;
   int          checks = 0, errors = 0;

   // Reference: entries in FIFO order with their stage position (0 = input side).
   logic [31:0] qd[$];
   int          qp[$];
   logic [31:0] got[$];

   always #5 clk = ~clk;

   reg_pipe_hs #(.DATA_WIDTH(32), .STAGES(S), .RST_VALUE(RV)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_count(o_count)
`ifdef REG_PIPE_HS_FLUSH_EN
      , .i_flush(flush)
`endif
   );

   function automatic bit exp_valid();
      return qd.size() > 0 && qp[0] == S-1;
   endfunction

   function automatic bit exp_ready();
      return qd.size() < S || i_ready;
   endfunction

   task automatic apply(input bit v, input logic [31:0] d, input bit r);
      i_valid = v;
      i_data  = d;
      i_ready = r;
      #1;
   endtask

   // Advance the model across one edge, then step past the DUT edge.
   task automatic tick();
      bit acc, out;
      int b;
      acc = i_valid && exp_ready();
      out = exp_valid() && i_ready;
      if (o_valid && i_ready && !i_rst && !flush) got.push_back(o_data);
      if (i_rst || flush) begin
         qd.delete();
         qp.delete();
      end else begin
         if (out) begin
            void'(qd.pop_front());
            void'(qp.pop_front());
         end
         for (int i = 0; i < qp.size(); i++) begin
            b = (i == 0) ? S-1 : qp[i-1] - 1;
            qp[i] = (qp[i] + 1 < b) ? qp[i] + 1 : b;
         end
         if (acc) begin
            qd.push_back(i_data);
            qp.push_back(0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      apply(0, 0, 0);
      tick();
      i_rst = 1'b0;
      got.delete();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      apply(1, 32'h1234, 0);
      tick();
      tick();
      i_rst = 1'b0;
      apply(0, 0, 0);
      checks++;
      if ({o_valid, o_count, o_ready} !== {1'b0, 2'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset valid/count/ready got %b/%0d/%b want 0/0/1", o_valid, o_count, o_ready);
      end
      checks++;
      if (o_data !== RV) begin
         errors++;
         $display("FAIL reset data got %h want %h", o_data, RV);
      end
   endtask

   task automatic test_stream();
      int first = -1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         apply(c < 5, 32'(c + 1), 1);
         if (o_valid && first < 0) first = c;
         checks++;
         if ({o_valid, o_count, o_ready} !== {exp_valid(), 2'(qd.size()), exp_ready()}) begin
            errors++;
            $display("FAIL stream c%0d v/cnt/rdy got %b/%0d/%b want %b/%0d/%b", c, o_valid, o_count, o_ready, exp_valid(), qd.size(), exp_ready());
         end
         if (exp_valid()) begin
            checks++;
            if (o_data !== qd[0]) begin
               errors++;
               $display("FAIL stream c%0d data got %h want %h", c, o_data, qd[0]);
            end
         end
         tick();
      end
      checks++;
      if (first !== 3) begin
         errors++;
         $display("FAIL stream latency first valid cycle %0d want 3", first);
      end
      checks++;
      if (got.size() != 5 || got[0] !== 1 || got[1] !== 2 || got[2] !== 3 || got[3] !== 4 || got[4] !== 5) begin
         errors++;
         $display("FAIL stream order got %p want 1..5", got);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] vals[4] = '{32'd10, 32'd11, 32'd12, 32'd13};
      int idx = 0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         apply(idx < 4, idx < 4 ? vals[idx] : 32'd0, c >= 6);
         checks++;
         if ({o_valid, o_count, o_ready} !== {exp_valid(), 2'(qd.size()), exp_ready()}) begin
            errors++;
            $display("FAIL backpressure c%0d v/cnt/rdy got %b/%0d/%b want %b/%0d/%b", c, o_valid, o_count, o_ready, exp_valid(), qd.size(), exp_ready());
         end
         if (c == 5) begin
            checks++;
            if (idx != 3 || o_ready !== 1'b0 || o_count !== 2'd3) begin
               errors++;
               $display("FAIL backpressure full accepted=%0d rdy=%b cnt=%0d want 3/0/3", idx, o_ready, o_count);
            end
         end
         if (idx < 4 && exp_ready()) idx++;
         tick();
      end
      checks++;
      if (got.size() != 4 || got[0] !== 10 || got[1] !== 11 || got[2] !== 12 || got[3] !== 13) begin
         errors++;
         $display("FAIL backpressure order got %p want 10..13", got);
      end
   endtask

   task automatic test_bubbles();
      logic [31:0] sb[$];
      logic [31:0] d;
      int acc_n = 0;
      do_reset();
      for (int c = 0; c < 210; c++) begin
         d = $urandom;
         apply(c < 200 && c % 2 == 0, d, c >= 200 || ($urandom % 2 == 1));
         checks++;
         if (o_count !== 2'(acc_n - got.size()) || o_valid !== exp_valid() || o_ready !== exp_ready()) begin
            errors++;
            $display("FAIL bubbles c%0d v/cnt/rdy got %b/%0d/%b want %b/%0d/%b", c, o_valid, o_count, o_ready, exp_valid(), acc_n - got.size(), exp_ready());
         end
         if (i_valid && exp_ready()) begin
            sb.push_back(d);
            acc_n++;
         end
         tick();
      end
      checks++;
      if (got.size() != sb.size() || got != sb) begin
         errors++;
         $display("FAIL bubbles scoreboard got %0d entries want %0d in FIFO order", got.size(), sb.size());
      end
   endtask

   task automatic test_full_simul();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         apply(1, 32'h100 + 32'(c), 0);
         tick();
      end
      for (int c = 0; c < 10; c++) begin
         apply(1, 32'h200 + 32'(c), 1);
         checks++;
         if ({o_valid, o_count, o_ready} !== {1'b1, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL full c%0d v/cnt/rdy got %b/%0d/%b want 1/3/1", c, o_valid, o_count, o_ready);
         end
         checks++;
         if (o_data !== qd[0]) begin
            errors++;
            $display("FAIL full c%0d data got %h want %h", c, o_data, qd[0]);
         end
         tick();
      end
   endtask

   task automatic test_discard(input bit use_flush);
      do_reset();
      for (int c = 0; c < 2; c++) begin
         apply(1, 32'h300 + 32'(c), 0);
         tick();
      end
      checks++;
      if (o_count !== 2'd2) begin
         errors++;
         $display("FAIL discard%0d precount got %0d want 2", use_flush, o_count);
      end
      if (use_flush) flush = 1'b1; else i_rst = 1'b1;
      apply(1, 32'h3FF, 1);
      tick();
      flush = 1'b0;
      i_rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         apply(0, 0, 1);
         checks++;
         if ({o_valid, o_count, o_ready} !== {1'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL discard%0d c%0d v/cnt/rdy got %b/%0d/%b want 0/0/1", use_flush, c, o_valid, o_count, o_ready);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_bubbles();
      test_full_simul();
      test_discard(0);
`ifdef REG_PIPE_HS_FLUSH_EN
      test_discard(1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reg_pipe_hs.md
# reg_pipe_hs

Parametrised valid/ready pipeline register chain for the base register library. It is the successor to the single enabled register: STAGES back-to-back storage stages with per-stage valid bits, bubble collapsing, backpressure, an occupancy count and an optional synchronous flush. It is used wherever a datapath needs cycle-alignment or timing cuts between handshaking units without losing throughput.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width in bits (>= 1)
- STAGES, 2, number of register stages (>= 1); also total capacity in entries
- RST_VALUE, 0, value loaded into every stage data register on reset

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  upstream offers i_data
- o_ready  output  1  chain accepts i_data this cycle
- i_data  input  DATA_WIDTH  upstream payload
- o_valid  output  1  last stage holds a valid entry
- i_ready  input  1  downstream accepts o_data
- o_data  output  DATA_WIDTH  payload of last stage
- o_count  output  $clog2(STAGES+1)  number of valid entries held
- i_flush  input  1  discard all held entries (present only with REG_PIPE_HS_FLUSH_EN)

## Operation
- Stage k (k = 0..STAGES-1, stage 0 nearest input) holds vld[k] and data[k]. The upstream of stage 0 is i_valid/i_data. The downstream of stage STAGES-1 is i_ready.
- Combinational ready chain: rdy[STAGES] = i_ready; rdy[k] = !vld[k] || rdy[k+1]; o_ready = rdy[0].
- On each edge, if rdy[k]:
  - vld[k] <= upstream valid.
  - data[k] <= upstream data only when upstream valid is 1. Otherwise data[k] holds its value.
- If !rdy[k], stage k holds both vld[k] and data[k].
- Bubbles collapse: an empty stage always loads, so a stalled output fills the chain until o_count == STAGES and o_ready drops.
- An input transfer happens when i_valid && o_ready. An output transfer happens when o_valid && i_ready.
- o_count = number of set vld bits. It is computed combinationally from the vld bits and is always consistent with them.
- Payload is never modified, duplicated or reordered. Entries leave in FIFO order.
- o_data is not required to be meaningful while o_valid = 0.
- Reset: all vld = 0 and all data = RST_VALUE. Resulting outputs: o_valid = 0, o_data = RST_VALUE, o_count = 0, o_ready = 1.
- Reset asserted mid-operation discards every held entry on that edge. Handshakes in the reset cycle are ignored.

## Timing
- Latency: an entry accepted at edge n appears on o_valid/o_data after edge n+STAGES-1, i.e. in the STAGES-th cycle after acceptance, when the chain is empty and i_ready = 1.
- Throughput: one transfer per cycle with continuous i_valid and i_ready.
- o_ready depends combinationally on i_ready through the STAGES-deep ready chain. This path is documented for integration timing.
- Full with i_ready = 1: o_ready = 1. Simultaneous input and output transfers are allowed, and o_count is unchanged.
- Full with i_ready = 0: o_ready = 0, and all state holds.
- Empty with i_valid = 1 and i_ready = 0: the entry advances to the last stage and waits there. o_count increases by 1 per accepted entry.

## Configuration
- REG_PIPE_HS_FLUSH_EN defined:
  - The i_flush port exists.
  - i_flush = 1 clears all vld bits on that edge. Data registers are untouched.
  - Flush takes priority over any input or output transfer in the same cycle. o_ready is still driven normally, and an entry accepted in the flush cycle is dropped.
  - Reset takes priority over flush.
- REG_PIPE_HS_FLUSH_EN undefined: the port is absent, and behaviour equals the flush-enabled block with i_flush tied to 0.

## Test plan
- Reset: STAGES=3, RST_VALUE=32'hDEAD_BEEF, i_rst high for 2 cycles -> o_valid=0, o_data=32'hDEAD_BEEF, o_count=0, o_ready=1.
- Streaming: STAGES=3, i_ready=1, i_valid=1 with data 1,2,3,4,5 on consecutive cycles -> o_valid first high 2 cycles after data 1 is accepted; then 1..5 appear on consecutive cycles; o_count stays at 3 in steady state.
- Backpressure fill: STAGES=3, i_ready=0, push 10,11,12,13 -> 10,11,12 accepted; o_ready=0 from the cycle o_count=3; 13 is held upstream. Release i_ready -> outputs 10,11,12,13 in order with no loss or duplication.
- Bubbles: alternate i_valid 1/0 with i_ready toggling in a pseudo-random pattern for 200 cycles -> scoreboard shows FIFO order; o_count equals accepted minus delivered every cycle.
- Full and simultaneous: chain full, i_valid=1, i_ready=1 -> one input and one output transfer per cycle; o_count constant at STAGES.
- Flush / mid-reset: with REG_PIPE_HS_FLUSH_EN, chain holding 2 entries, i_flush=1 together with i_valid=1 -> next cycle o_count=0 and o_valid=0, and the input is dropped. Repeat with i_rst instead of i_flush, in the flush build and the non-flush build -> same result.
